// File: rtl/conv_axil_pkg.sv
// Shared types and constants for the convolver AXI4-Lite master.
// State encoding, AXI response codes and fixed protection bits.
package conv_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/conv_axil_master.sv
// Single-outstanding AXI4-Lite initiator for the convolver register slave.
// Turns valid/ready commands into AXI transactions and returns the response.
module conv_axil_master
  import conv_axil_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_we,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs;
  logic   w_hs;

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;

  assign m_axi_awprot = AXPROT_DEFAULT;
  assign m_axi_arprot = AXPROT_DEFAULT;
  assign m_axi_wstrb  = '1;

  // Transaction FSM; every handshake output is a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_we        <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready    <= 1'b0;
            rsp_we       <= cmd_we;
            m_axi_awaddr <= cmd_addr;
            m_axi_araddr <= cmd_addr;
            m_axi_wdata  <= cmd_wdata;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            if (cmd_we) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
        WR: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_axil_master.sv
// Bench for conv_axil_master: directed commands against a small
// register-slave model, with a queue-based response scoreboard.
module tb_conv_axil_master;
  import conv_axil_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid;
  logic          m_axi_wready = 1'b0;
  logic [1:0]    m_axi_bresp = 2'b00;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;
  logic [AW-1:0] m_axi_araddr;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = 2'b00;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;

  always #5 clk = ~clk;

  conv_axil_master #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we(cmd_we),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   n_rsp = 0;
  rsp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rsp_t mk(input logic we, input logic [DW-1:0] d,
                              input logic [1:0] r);
    rsp_t e;
    e.we    = we;
    e.rdata = d;
    e.resp  = r;
    return e;
  endfunction

  // Slave model knobs, set by the stimulus process.
  int         aw_delay = 0;
  int         w_delay  = 0;
  int         ar_delay = 0;
  logic [1:0] rresp_cfg = 2'b00;

  logic [DW-1:0] mem [8];
  int            aw_cnt = 0;
  int            w_cnt = 0;
  int            ar_cnt = 0;
  logic          got_aw = 0;
  logic          got_w = 0;
  logic          got_ar = 0;
  logic [AW-1:0] s_awaddr, s_araddr, awaddr_q, araddr_q;
  logic [DW-1:0] s_wdata, wdata_q;
  logic          bready_q = 0;
  logic          rready_q = 0;

  // Register slave: drives at negedge; a ready held over a cycle
  // means the handshake happened at the posedge in between.
  always @(negedge clk) begin
    if (!rst) begin
      m_axi_awready = 0;
      m_axi_wready  = 0;
      m_axi_arready = 0;
      m_axi_bvalid  = 0;
      m_axi_rvalid  = 0;
      m_axi_bresp   = 0;
      m_axi_rresp   = 0;
      m_axi_rdata   = 0;
      got_aw = 0; got_w = 0; got_ar = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      bready_q = 0; rready_q = 0;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      mem[4] = 32'h0000_00A5;
    end else begin
      if (m_axi_awready) begin
        got_aw = 1; s_awaddr = awaddr_q; aw_cnt = 0;
      end
      if (m_axi_wready) begin
        got_w = 1; s_wdata = wdata_q; w_cnt = 0;
      end
      if (m_axi_arready) begin
        got_ar = 1; s_araddr = araddr_q; ar_cnt = 0;
      end
      if (m_axi_bvalid && bready_q) m_axi_bvalid = 0;
      if (m_axi_rvalid && rready_q) m_axi_rvalid = 0;
      if (got_aw && got_w && !m_axi_bvalid) begin
        mem[s_awaddr[4:2]] = s_wdata;
        m_axi_bresp  = RESP_OKAY;
        m_axi_bvalid = 1;
        got_aw = 0;
        got_w  = 0;
      end
      if (got_ar && !m_axi_rvalid) begin
        m_axi_rdata  = mem[s_araddr[4:2]];
        m_axi_rresp  = rresp_cfg;
        m_axi_rvalid = 1;
        got_ar = 0;
      end
      m_axi_awready = m_axi_awvalid && !got_aw && aw_cnt >= aw_delay;
      if (m_axi_awvalid && !got_aw && !m_axi_awready) aw_cnt++;
      m_axi_wready = m_axi_wvalid && !got_w && w_cnt >= w_delay;
      if (m_axi_wvalid && !got_w && !m_axi_wready) w_cnt++;
      m_axi_arready = m_axi_arvalid && !got_ar && ar_cnt >= ar_delay;
      if (m_axi_arvalid && !got_ar && !m_axi_arready) ar_cnt++;
      bready_q = m_axi_bready;
      rready_q = m_axi_rready;
      awaddr_q = m_axi_awaddr;
      wdata_q  = m_axi_wdata;
      araddr_q = m_axi_araddr;
    end
  end

  // Response monitor: pops one expectation per accepted response.
  always @(negedge clk) begin
    rsp_t e;
    if (rst) begin
      chk("rsp_cmd_excl", {31'b0, rsp_valid & cmd_ready}, 32'd0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_rsp: got we=%b rdata=%h resp=%b want none",
                   rsp_we, rsp_rdata, rsp_resp);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_we", {31'b0, rsp_we}, {31'b0, e.we});
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", {30'b0, rsp_resp}, {30'b0, e.resp});
          n_rsp++;
        end
      end
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_ready && t < 50);
    chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
  endtask

  // Issue one command; returns just after the accepting edge (edge 0).
  task automatic send(input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit push,
                      input rsp_t e);
    wait_ready();
    cmd_valid = 1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int t;
    cmd_valid = 0;
    cmd_we    = 0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1;

    #2 rst = 0;
    #1;
    chk("rst_awvalid", {31'b0, m_axi_awvalid}, 0);
    chk("rst_wvalid", {31'b0, m_axi_wvalid}, 0);
    chk("rst_arvalid", {31'b0, m_axi_arvalid}, 0);
    chk("rst_bready", {31'b0, m_axi_bready}, 0);
    chk("rst_rready", {31'b0, m_axi_rready}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 0);
    chk("rst_awaddr", {27'b0, m_axi_awaddr}, 0);
    chk("rst_araddr", {27'b0, m_axi_araddr}, 0);
    chk("rst_wdata", m_axi_wdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", {30'b0, rsp_resp}, 0);
    chk("rst_rsp_we", {31'b0, rsp_we}, 0);
    @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
    chk("cmd_ready_after_rst", {31'b0, cmd_ready}, 1);

    // Zero-wait write.
    send(1, 5'h04, 32'hDEAD_BEEF, 1, mk(1, 32'h0, RESP_OKAY));
    @(negedge clk);
    chk("w0_c1_awvalid", {31'b0, m_axi_awvalid}, 1);
    chk("w0_c1_wvalid", {31'b0, m_axi_wvalid}, 1);
    chk("w0_c1_wstrb", {28'b0, m_axi_wstrb}, 32'hF);
    chk("w0_c1_awaddr", {27'b0, m_axi_awaddr}, 32'h04);
    chk("w0_c1_wdata", m_axi_wdata, 32'hDEAD_BEEF);
    chk("w0_c1_awprot", {29'b0, m_axi_awprot}, 0);
    @(negedge clk);
    chk("w0_c2_awvalid", {31'b0, m_axi_awvalid}, 0);
    chk("w0_c2_wvalid", {31'b0, m_axi_wvalid}, 0);
    chk("w0_c2_bready", {31'b0, m_axi_bready}, 1);
    @(negedge clk);
    chk("w0_c3_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("w0_c3_bready", {31'b0, m_axi_bready}, 0);

    // Write with AWREADY three cycles late.
    aw_delay = 3;
    send(1, 5'h08, 32'hCAFE_0001, 1, mk(1, 32'h0, RESP_OKAY));
    @(negedge clk);
    chk("w1_c1_awvalid", {31'b0, m_axi_awvalid}, 1);
    chk("w1_c1_wvalid", {31'b0, m_axi_wvalid}, 1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk("w1_awvalid_hold", {31'b0, m_axi_awvalid}, 1);
      chk("w1_wvalid_low", {31'b0, m_axi_wvalid}, 0);
      chk("w1_bready_low", {31'b0, m_axi_bready}, 0);
    end
    @(negedge clk);
    chk("w1_c5_awvalid", {31'b0, m_axi_awvalid}, 0);
    chk("w1_c5_bready", {31'b0, m_axi_bready}, 1);
    aw_delay = 0;

    // Read with SLVERR from the preset register at 0x10.
    rresp_cfg = RESP_SLVERR;
    send(0, 5'h10, 32'h0, 1, mk(0, 32'h0000_00A5, RESP_SLVERR));
    @(negedge clk);
    chk("r0_c1_arvalid", {31'b0, m_axi_arvalid}, 1);
    chk("r0_c1_araddr", {27'b0, m_axi_araddr}, 32'h10);
    chk("r0_c1_arprot", {29'b0, m_axi_arprot}, 0);
    chk("r0_c1_awvalid", {31'b0, m_axi_awvalid}, 0);
    @(negedge clk);
    chk("r0_c2_arvalid", {31'b0, m_axi_arvalid}, 0);
    chk("r0_c2_rready", {31'b0, m_axi_rready}, 1);
    @(negedge clk);
    chk("r0_c3_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("r0_c3_rready", {31'b0, m_axi_rready}, 0);
    rresp_cfg = RESP_OKAY;

    // Read back 0x04 with the consumer stalled for five cycles.
    send(0, 5'h04, 32'h0, 1, mk(0, 32'hDEAD_BEEF, RESP_OKAY));
    rsp_ready = 0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 3; i <= 7; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_cmd_ready", {31'b0, cmd_ready}, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1;
    @(negedge clk);
    chk("bp_c8_rsp_valid", {31'b0, rsp_valid}, 1);
    @(negedge clk);
    chk("bp_c9_cmd_ready", {31'b0, cmd_ready}, 1);
    chk("bp_c9_rsp_valid", {31'b0, rsp_valid}, 0);

    // Reset while ARVALID waits on a stalled ARREADY.
    ar_delay = 100;
    send(0, 5'h0C, 32'h0, 0, mk(0, 32'h0, RESP_OKAY));
    @(negedge clk);
    chk("ra_c1_arvalid", {31'b0, m_axi_arvalid}, 1);
    @(negedge clk);
    chk("ra_c2_arvalid", {31'b0, m_axi_arvalid}, 1);
    #2 rst = 0;
    #1;
    chk("ra_async_arvalid", {31'b0, m_axi_arvalid}, 0);
    chk("ra_async_cmd_ready", {31'b0, cmd_ready}, 0);
    ar_delay = 0;
    @(negedge clk);
    #2 rst = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ra_cmd_ready", {31'b0, cmd_ready}, 1);
      chk("ra_no_rsp", {31'b0, rsp_valid}, 0);
    end

    // Back-to-back write then read of register 0.
    send(1, 5'h00, 32'h1234_5678, 1, mk(1, 32'h0, RESP_OKAY));
    send(0, 5'h00, 32'h0, 1, mk(0, 32'h1234_5678, RESP_OKAY));

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    chk("rsp_count", n_rsp, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
